ch_level_search: RTL

- Per-channel measurement sequencer between the strobe generator and the threshold DAC SPI master.
- For each delay-line code it steps the comparator threshold upward from 0 until the sampled comparator output differs from its level at threshold 0, then emits one (threshold, delay) waveform point.
- It then advances the delay code and repeats until the delay range is exhausted.
- Two instances exist, one per channel.

---
 rtl/ch_level_search.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ch_level_search.sv
`default_nettype none
// ============================================================================
// Module   : ch_level_search
// Purpose  : Per-channel level-crossing search sequencer. For each delay-line
//            code it raises the comparator threshold from 0 in steps until the
//            sampled comparator output differs from its level at threshold 0.
//            It then emits one (threshold, delay) point and advances the
//            delay code until the delay range is exhausted.
// Ports    : clk_i / arst_i              - clock, async active-high reset
//            run_i / abort_i             - start / stop pulses
//            stb_i                       - sampling strobe (clk_i domain)
//            cmp_out_i                   - asynchronous comparator output
//            threshold_delta_i           - threshold step (0 treated as 1)
//            d_code_delta_i              - delay step (0 treated as 1)
//            threshold_o/_wre_o/_rdy_i   - DAC code and SPI write handshake
//            d_code_o                    - delay-line code
//            busy_o / done_o             - sweep status
//            point_rdy_o/_v_o/_t_o/_miss_o - waveform point output
// Revision : 1.0 - initial release
// ============================================================================
module ch_level_search #(
    parameter int DAC_CODE_WIDTH  = 16,
    parameter int D_CODE_WIDTH    = 10,
    parameter int SETTLE_STROBES  = 2,
    parameter int CMP_SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      run_i,
    input  logic                      abort_i,
    input  logic                      stb_i,
    input  logic                      cmp_out_i,
    input  logic [DAC_CODE_WIDTH-1:0] threshold_delta_i,
    input  logic [D_CODE_WIDTH-1:0]   d_code_delta_i,
    output logic [DAC_CODE_WIDTH-1:0] threshold_o,
    output logic                      threshold_wre_o,
    input  logic                      threshold_rdy_i,
    output logic [D_CODE_WIDTH-1:0]   d_code_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      point_rdy_o,
    output logic [DAC_CODE_WIDTH-1:0] point_v_o,
    output logic [D_CODE_WIDTH-1:0]   point_t_o,
    output logic                      point_miss_o
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_set_dac  = 3'd1;
    localparam logic [2:0] c_st_wait_dac = 3'd2;
    localparam logic [2:0] c_st_settle   = 3'd3;
    localparam logic [2:0] c_st_sample   = 3'd4;
    localparam logic [2:0] c_st_step_thr = 3'd5;
    localparam logic [2:0] c_st_emit     = 3'd6;
    localparam logic [2:0] c_st_next_d   = 3'd7;

    localparam logic [3:0]                c_settle   = 4'(SETTLE_STROBES);
    localparam logic [DAC_CODE_WIDTH-1:0] c_thr_one  = {{(DAC_CODE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [D_CODE_WIDTH-1:0]   c_d_one    = {{(D_CODE_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                 r_state;
    logic [CMP_SYNC_STAGES-1:0] r_cmp_sync;
    logic [CMP_SYNC_STAGES-1:0] r_stb_dly;
    logic [DAC_CODE_WIDTH-1:0]  r_threshold;
    logic [D_CODE_WIDTH-1:0]    r_d_code;
    logic [3:0]                 r_settle_cnt;
    logic                       r_wait_first;
    logic                       r_ref;
    logic                       r_ref_valid;
    logic                       r_miss;

    logic                       w_cmp_s;
    logic                       w_stb_d;
    logic [DAC_CODE_WIDTH-1:0]  w_thr_step;
    logic [D_CODE_WIDTH-1:0]    w_d_step;
    logic [DAC_CODE_WIDTH:0]    w_thr_sum;
    logic [D_CODE_WIDTH:0]      w_d_sum;

    // Comparator synchronizer; the strobe goes through a delay line of the
    // same depth so each strobe lines up with the comparator level it caused.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cmp_sync <= '0;
            r_stb_dly  <= '0;
        end else begin
            r_cmp_sync <= {r_cmp_sync[CMP_SYNC_STAGES-2:0], cmp_out_i};
            r_stb_dly  <= {r_stb_dly[CMP_SYNC_STAGES-2:0], stb_i};
        end
    end

    assign w_cmp_s = r_cmp_sync[CMP_SYNC_STAGES-1];
    assign w_stb_d = r_stb_dly[CMP_SYNC_STAGES-1];

    // Step inputs are live (not latched at run); a zero step would never
    // terminate, so it is forced to one.
    assign w_thr_step = (threshold_delta_i == '0) ? c_thr_one : threshold_delta_i;
    assign w_d_step   = (d_code_delta_i == '0) ? c_d_one : d_code_delta_i;
    assign w_thr_sum  = {1'b0, r_threshold} + {1'b0, w_thr_step};
    assign w_d_sum    = {1'b0, r_d_code} + {1'b0, w_d_step};

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= c_st_idle;
            r_threshold  <= '0;
            r_d_code     <= '0;
            r_settle_cnt <= '0;
            r_wait_first <= 1'b0;
            r_ref        <= 1'b0;
            r_ref_valid  <= 1'b0;
            r_miss       <= 1'b0;
        end else if (abort_i && (r_state != c_st_idle)) begin
            // Abort outranks every other event; codes are left as they are.
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (run_i && !abort_i) begin
                        r_threshold <= '0;
                        r_d_code    <= '0;
                        r_ref_valid <= 1'b0;
                        r_state     <= c_st_set_dac;
                    end
                end
                c_st_set_dac: begin
                    r_wait_first <= 1'b1;
                    r_state      <= c_st_wait_dac;
                end
                c_st_wait_dac: begin
                    // The SPI master may not drop rdy until a cycle after the
                    // request, so rdy is not trusted in the first cycle.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (threshold_rdy_i) begin
                        r_settle_cnt <= c_settle;
                        r_state      <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= c_st_sample;
                    end else if (w_stb_d) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                        if (r_settle_cnt == 4'd1) begin
                            r_state <= c_st_sample;
                        end
                    end
                end
                c_st_sample: begin
                    if (w_stb_d) begin
                        if (!r_ref_valid) begin
                            r_ref       <= w_cmp_s;
                            r_ref_valid <= 1'b1;
                            r_state     <= c_st_step_thr;
                        end else if (w_cmp_s != r_ref) begin
                            r_miss  <= 1'b0;
                            r_state <= c_st_emit;
                        end else begin
                            r_state <= c_st_step_thr;
                        end
                    end
                end
                c_st_step_thr: begin
                    if (w_thr_sum[DAC_CODE_WIDTH]) begin
                        r_miss  <= 1'b1;
                        r_state <= c_st_emit;
                    end else begin
                        r_threshold <= w_thr_sum[DAC_CODE_WIDTH-1:0];
                        r_state     <= c_st_set_dac;
                    end
                end
                c_st_emit: begin
                    r_state <= c_st_next_d;
                end
                c_st_next_d: begin
                    if (w_d_sum[D_CODE_WIDTH]) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_d_code    <= w_d_sum[D_CODE_WIDTH-1:0];
                        r_threshold <= '0;
                        r_ref_valid <= 1'b0;
                        r_state     <= c_st_set_dac;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Pulse outputs are gated by abort_i so an abort cycle never issues a
    // write, a point or a done.
    assign threshold_o     = r_threshold;
    assign d_code_o        = r_d_code;
    assign busy_o          = (r_state != c_st_idle);
    assign threshold_wre_o = (r_state == c_st_set_dac) && !abort_i;
    assign point_rdy_o     = (r_state == c_st_emit) && !abort_i;
    assign done_o          = (r_state == c_st_next_d) && w_d_sum[D_CODE_WIDTH] && !abort_i;
    assign point_v_o       = point_rdy_o ? (r_miss ? '1 : r_threshold) : '0;
    assign point_t_o       = point_rdy_o ? r_d_code : '0;
    assign point_miss_o    = point_rdy_o && r_miss;

endmodule
`default_nettype wire
